// File: rtl/bandit_pkg.sv
// Shared types and constants for the one-arm-bandit reel and scoring blocks.
package bandit_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPIN3 = 3'd1,
        ST_SPIN2 = 3'd2,
        ST_SPIN1 = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    localparam logic [1:0] REEL_NONE = 2'd0;
    localparam logic [1:0] REEL_1    = 2'd1;
    localparam logic [1:0] REEL_2    = 2'd2;
    localparam logic [1:0] REEL_3    = 2'd3;

    // Modular add on a 0..dmax digit; the 5-bit sum keeps the carry out of 4 bits.
    function automatic logic [DIGIT_W-1:0] reel_wrap(
        input logic [DIGIT_W-1:0] v,
        input logic [DIGIT_W-1:0] step,
        input logic [DIGIT_W-1:0] dmax
    );
        logic [DIGIT_W:0] sum;
        sum = {1'b0, v} + {1'b0, step};
        sum = (sum > {1'b0, dmax}) ? (sum - ({1'b0, dmax} + 5'd1)) : sum;
        return sum[DIGIT_W-1:0];
    endfunction

endpackage

// File: rtl/reel_counter.sv
// One decimal reel: advances by STEP on every tick unless held.
module reel_counter
    import bandit_pkg::*;
#(
    parameter int STEP      = 1,
    parameter int DIGIT_MAX = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               hold,
    output logic [DIGIT_W-1:0] value
);

    localparam logic [DIGIT_W-1:0] STEP_V = DIGIT_W'(STEP);
    localparam logic [DIGIT_W-1:0] DMAX_V = DIGIT_W'(DIGIT_MAX);

    logic [DIGIT_W-1:0] r_value;

    // Reel register; frozen value persists until the next spin steps it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= 4'd0;
        end else if (tick && !hold) begin
            r_value <= reel_wrap(r_value, STEP_V, DMAX_V);
        end else begin
            r_value <= r_value;
        end
    end

    assign value = r_value;

endmodule

// File: rtl/reel_spinner.sv
// Reel-side controller: spins three reels, freezes them on stop presses and
// hands the frozen triple to the scorer.
module reel_spinner
    import bandit_pkg::*;
#(
    parameter int SPIN_DIV  = 4,
    parameter int DIGIT_MAX = 9,
    parameter int STEP1     = 1,
    parameter int STEP2     = 3,
    parameter int STEP3     = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_p,
    input  logic               stop_p,
    input  logic               pass_p,
    output logic [DIGIT_W-1:0] number1,
    output logic [DIGIT_W-1:0] number2,
    output logic [DIGIT_W-1:0] number3,
    output logic               turn_p,
    output logic               ref_sign,
    output logic [1:0]         refresh,
    output logic               busy
);

    localparam int            PW         = $clog2(SPIN_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SPIN_DIV - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_next;
    logic          w_spinning;
    logic          w_tick;
    logic [2:0]    w_hold;
    logic          w_ref_next;
    logic          w_turn_next;
    logic [1:0]    w_refresh_next;
    logic          r_turn_p;
    logic          r_ref_sign;
    logic [1:0]    r_refresh;
    logic          r_busy;

    assign w_spinning = (r_state == ST_SPIN3) || (r_state == ST_SPIN2) || (r_state == ST_SPIN1);
    assign w_tick     = w_spinning && (r_presc == PRESC_LAST);

    // Next state, prescaler and pulses; the stopping reel is held through a coincident tick.
    always_comb begin
        w_next_state   = r_state;
        w_presc_next   = r_presc;
        w_hold         = 3'b111;
        w_ref_next     = 1'b0;
        w_turn_next    = 1'b0;
        w_refresh_next = r_refresh;
        if (w_spinning) begin
            w_presc_next = w_tick ? {PW{1'b0}} : (r_presc + PW'(1));
        end else begin
            w_presc_next = r_presc;
        end
        case (r_state)
            ST_IDLE: begin
                if (start_p) begin
                    w_next_state = ST_SPIN3;
                    w_presc_next = {PW{1'b0}};
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SPIN3: begin
                w_hold = {1'b0, 1'b0, stop_p};
                if (stop_p) begin
                    w_next_state   = ST_SPIN2;
                    w_refresh_next = REEL_1;
                    w_ref_next     = 1'b1;
                end else begin
                    w_next_state = ST_SPIN3;
                end
            end
            ST_SPIN2: begin
                w_hold = {1'b0, stop_p, 1'b1};
                if (stop_p) begin
                    w_next_state   = ST_SPIN1;
                    w_refresh_next = REEL_2;
                    w_ref_next     = 1'b1;
                end else begin
                    w_next_state = ST_SPIN2;
                end
            end
            ST_SPIN1: begin
                w_hold = {stop_p, 1'b1, 1'b1};
                if (stop_p) begin
                    w_next_state   = ST_WAIT;
                    w_refresh_next = REEL_3;
                    w_ref_next     = 1'b1;
                    w_turn_next    = 1'b1;
                end else begin
                    w_next_state = ST_SPIN1;
                end
            end
            ST_WAIT: begin
                // The scorer cannot have consumed a turn it is only now being shown.
                if (pass_p && !r_turn_p) begin
                    w_next_state   = ST_IDLE;
                    w_refresh_next = REEL_NONE;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            default: begin
                w_next_state   = ST_IDLE;
                w_refresh_next = REEL_NONE;
            end
        endcase
    end

    // State and prescaler registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_presc <= {PW{1'b0}};
        end else begin
            r_state <= w_next_state;
            r_presc <= w_presc_next;
        end
    end

    // Registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_turn_p   <= 1'b0;
            r_ref_sign <= 1'b0;
            r_refresh  <= REEL_NONE;
            r_busy     <= 1'b0;
        end else begin
            r_turn_p   <= w_turn_next;
            r_ref_sign <= w_ref_next;
            r_refresh  <= w_refresh_next;
            r_busy     <= (w_next_state != ST_IDLE);
        end
    end

    reel_counter #(.STEP(STEP1), .DIGIT_MAX(DIGIT_MAX)) u_reel1 (
        .clk(clk), .rst_n(rst_n), .tick(w_tick), .hold(w_hold[0]), .value(number1)
    );
    reel_counter #(.STEP(STEP2), .DIGIT_MAX(DIGIT_MAX)) u_reel2 (
        .clk(clk), .rst_n(rst_n), .tick(w_tick), .hold(w_hold[1]), .value(number2)
    );
    reel_counter #(.STEP(STEP3), .DIGIT_MAX(DIGIT_MAX)) u_reel3 (
        .clk(clk), .rst_n(rst_n), .tick(w_tick), .hold(w_hold[2]), .value(number3)
    );

    assign turn_p   = r_turn_p;
    assign ref_sign = r_ref_sign;
    assign refresh  = r_refresh;
    assign busy     = r_busy;

endmodule

// File: doc/reel_spinner.md
# reel_spinner

Drives the reel side of the one-arm-bandit scoring interface: spins three decimal reels, freezes them one at a time on player stop presses, and presents the frozen values to the scoring block. It sources `number1..number3`, `turn_p`, `ref_sign` and `refresh`, and consumes `pass_p`. It sits between the debounced button pulses and the scorer.

## Interface
Parameters:
- `SPIN_DIV`, default 4: clock cycles per reel step; must be at least 2.
- `DIGIT_MAX`, default 9: the largest reel value. Reels run 0..`DIGIT_MAX`; must be at most 15.
- `STEP1` / `STEP2` / `STEP3`, defaults 1 / 3 / 7: per-tick increment of each reel; each must be at most `DIGIT_MAX`.

Ports:
- `clk`  in  1: the single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start_p`  in  1: one-cycle pulse that requests a spin.
- `stop_p`  in  1: one-cycle pulse that stops the next reel.
- `pass_p`  in  1: one-cycle pulse from the scorer; the score is consumed.
- `number1`, `number2`, `number3`  out  4: current value of each reel.
- `turn_p`  out  1: one-cycle pulse; all three reels are frozen and valid.
- `ref_sign`  out  1: one-cycle pulse; a reel has just frozen.
- `refresh`  out  2: index of the last frozen reel (1..3). It is 0 in IDLE.
- `busy`  out  1: high in every state except IDLE.

## Operation
- States are IDLE, SPIN3, SPIN2, SPIN1 and WAIT. The name gives the number of reels still spinning.
- **IDLE**
  - `start_p` moves the block to SPIN3 and clears the prescaler.
  - `stop_p` and `pass_p` are ignored.
- **Prescaler**
  - Counts 0..`SPIN_DIV`-1 in every SPIN state.
  - Issues `tick` when the count equals `SPIN_DIV`-1, then wraps to 0.
- **Reel stepping**
  - On each `tick`, every spinning reel k adds `STEPk`.
  - If the sum exceeds `DIGIT_MAX`, the result is the sum minus (`DIGIT_MAX`+1).
  - Use a 5-bit intermediate for the sum. No other wrap rule is allowed.
- **Stopping reels**
  - `stop_p` in SPIN3 freezes reel 1, sets `refresh`=1, pulses `ref_sign` and moves to SPIN2.
  - `stop_p` in SPIN2 does the same for reel 2, with `refresh`=2, and moves to SPIN1.
  - `stop_p` in SPIN1 freezes reel 3, sets `refresh`=3, pulses `ref_sign` and `turn_p` together, and moves to WAIT.
- **WAIT**
  - All reels hold their values.
  - `pass_p` moves the block to IDLE and clears `refresh` to 0.
  - `start_p` and `stop_p` are ignored.
  - The block stays in WAIT indefinitely until `pass_p` arrives.
- Reels keep their frozen values across IDLE. The next spin continues from those values.
- **Boundary cases**
  - If `stop_p` and `tick` occur in the same cycle, the stopping reel keeps its pre-tick value. The other spinning reels still step.
  - `start_p` in a SPIN state or in WAIT is ignored.
  - `pass_p` outside WAIT is ignored, including the cycle in which `turn_p` is high.
  - If `start_p` and `pass_p` occur together in WAIT, the block goes to IDLE only. It does not start a spin.
- **Reset** (asynchronous, at any point):
  - state becomes IDLE and the prescaler becomes 0;
  - every `number` output, `turn_p`, `ref_sign`, `refresh` and `busy` become 0.

## Timing
- All outputs are registered.
- Start latency:
  - `start_p` sampled high at edge N gives `busy`=1 after edge N.
  - The first `tick` is at edge N+`SPIN_DIV`.
  - Reel values change after that edge.
- Stop latency:
  - `stop_p` sampled at edge N gives `ref_sign`, the new `refresh` and the frozen value after edge N.
  - These are valid during cycle N+1.
- `ref_sign` and `turn_p` are high for exactly one cycle. `number1..3` are stable whenever `turn_p`=1.
- Pass handling: `pass_p` sampled at edge M gives `busy`=0 and `refresh`=0 after edge M.
- The minimum spacing between useful `stop_p` pulses is 1 cycle. Back-to-back pulses stop consecutive reels.

## Structure
- Shared package `bandit_pkg` holds:
  - the state enum;
  - `REEL_NONE`=0, `REEL_1`=1, `REEL_2`=2, `REEL_3`=3;
  - the digit width of 4.
- Sub-module `reel_counter`, instantiated three times. It has:
  - parameters `STEP` and `DIGIT_MAX`;
  - inputs `clk`, `rst_n`, `tick` and `hold`;
  - output `value` with 4 bits.
  - Its value advances on `tick` and `!hold`, using the wrap rule above.
- The top level owns the FSM, the prescaler, and the `hold` vector and pulse generation.

## Test plan
All scenarios use the default parameters.
1. **Reset state.** Assert `rst_n`=0 in the middle of a spin. Required: all outputs are 0 immediately, without waiting for a clock edge. After release, the block is in IDLE and `busy`=0.
2. **Stepping and wrap.**
   - Stimulus: `start_p` from reset, no stops, run for 3 ticks (12 cycles).
   - Required values after each tick:
     - tick 1: 1, 3, 7;
     - tick 2: 2, 6, 4;
     - tick 3: 3, 9, 1.
3. **Full turn.**
   - Stimulus: from scenario 2, send `stop_p` three times, one cycle apart.
   - Required: `refresh` goes 1→2→3 with three `ref_sign` pulses. `turn_p` is a single pulse together with the third one. The outputs hold 3/9/1.
   - Then `pass_p`: `busy`=0 and `refresh`=0 on the next cycle.
4. **Stop coincident with tick.**
   - Stimulus: in SPIN3, raise `stop_p` on the tick cycle when the reels show 3/9/1.
   - Required: reel 1 stays 3, while reels 2 and 3 step to 2 and 8.
5. **Ignored inputs.**
   - Stimulus: `start_p` during SPIN2; `stop_p` and `pass_p` in IDLE; `pass_p` in the same cycle as `turn_p`.
   - Required: no state change in any case, and the block remains in WAIT after the last one.
6. **Start with pass.** Send `start_p` and `pass_p` in the same cycle while in WAIT. Required: the block ends in IDLE with `busy`=0, and the reels do not step.
